// File: rtl/aes_dec_cbc_ctrl_if.sv
// Bundle of the upstream ciphertext stream, the AES core handshake and the plaintext stream.
// The slave modport is the controller's view; the master modport is the surrounding environment.
interface aes_dec_cbc_ctrl_if;
    localparam int unsigned DW = 128;
    localparam int unsigned CW = 16;

    // IV loading
    logic          iv_load;
    logic [DW-1:0] iv;

    // ciphertext input stream
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_ctxt;
    logic          s_last;

    // iterative decrypt core
    logic          core_rst;
    logic [DW-1:0] core_ctxt;
    logic          core_done;
    logic [DW-1:0] core_ptxt;

    // plaintext output stream
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_ptxt;
    logic          m_last;

    // status
    logic          err_timeout;
    logic [CW-1:0] blk_cnt;

    modport slave (
        input  iv_load,
        input  iv,
        input  s_valid,
        input  s_ctxt,
        input  s_last,
        input  core_done,
        input  core_ptxt,
        input  m_ready,
        output s_ready,
        output core_rst,
        output core_ctxt,
        output m_valid,
        output m_ptxt,
        output m_last,
        output err_timeout,
        output blk_cnt
    );

    modport master (
        output iv_load,
        output iv,
        output s_valid,
        output s_ctxt,
        output s_last,
        output core_done,
        output core_ptxt,
        output m_ready,
        input  s_ready,
        input  core_rst,
        input  core_ctxt,
        input  m_valid,
        input  m_ptxt,
        input  m_last,
        input  err_timeout,
        input  blk_cnt
    );
endinterface

// File: rtl/aes_dec_cbc_ctrl.sv
// CBC-mode decrypt controller around an iterative AES decrypt core: sequences one block
// at a time, XORs the core result with the chain value and tracks IV/chain state per message.
module aes_dec_cbc_ctrl #(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              reset,
    aes_dec_cbc_ctrl_if.slave bus
);
    localparam int unsigned DW = 128;
    localparam int unsigned CW = 16;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    // Done pulses seen in the first two WAIT cycles may belong to the previous block.
    localparam int unsigned STALE_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [DW-1:0] iv_q;
    logic [DW-1:0] chain_q;
    logic [DW-1:0] core_ctxt_q;
    logic [DW-1:0] m_ptxt_q;
    logic          last_q;
    logic          m_last_q;
    logic          err_q;
    logic          core_rst_q;
    logic [CW-1:0] blk_cnt_q;
    logic [WW-1:0] wait_cnt;

    logic          done_ok;
    logic          wait_expired;
    logic          s_ready_c;
    logic          m_valid_c;

    // A done only counts once the stale window after core_rst has passed.
    assign done_ok      = (state == WAIT) && bus.core_done &&
                          (wait_cnt >= WW'(STALE_CYCLES));
    assign wait_expired = (state == WAIT) && !done_ok &&
                          (wait_cnt == WW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.s_valid) begin
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (done_ok) begin
                    state_nxt = OUT;
                end else if (wait_expired) begin
                    state_nxt = IDLE;
                end
            end
            OUT: begin
                if (bus.m_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from state alone
    always_comb begin
        s_ready_c = 1'b0;
        m_valid_c = 1'b0;
        case (state)
            IDLE:    s_ready_c = 1'b1;
            OUT:     m_valid_c = 1'b1;
            default: begin
                s_ready_c = 1'b0;
                m_valid_c = 1'b0;
            end
        endcase
    end

    // Datapath and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iv_q        <= '0;
            chain_q     <= '0;
            core_ctxt_q <= '0;
            m_ptxt_q    <= '0;
            last_q      <= 1'b0;
            m_last_q    <= 1'b0;
            err_q       <= 1'b0;
            core_rst_q  <= 1'b1;
            blk_cnt_q   <= '0;
            wait_cnt    <= '0;
        end else begin
            core_rst_q <= (state_nxt == START);

            // IV load lands first so a block accepted on the same edge chains from it.
            if (state == IDLE) begin
                if (bus.iv_load) begin
                    iv_q    <= bus.iv;
                    chain_q <= bus.iv;
                end
                if (bus.s_valid) begin
                    core_ctxt_q <= bus.s_ctxt;
                    last_q      <= bus.s_last;
                end
            end

            if (state == START) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + WW'(1);
            end

            // After the last block of a message the chain restarts from the IV.
            if (done_ok) begin
                m_ptxt_q <= bus.core_ptxt ^ chain_q;
                m_last_q <= last_q;
                chain_q  <= last_q ? iv_q : core_ctxt_q;
            end

            if (wait_expired) begin
                err_q <= 1'b1;
            end

            if ((state == OUT) && bus.m_ready) begin
                blk_cnt_q <= blk_cnt_q + CW'(1);
            end
        end
    end

    assign bus.s_ready     = s_ready_c;
    assign bus.m_valid     = m_valid_c;
    assign bus.core_rst    = core_rst_q;
    assign bus.core_ctxt   = core_ctxt_q;
    assign bus.m_ptxt      = m_ptxt_q;
    assign bus.m_last      = m_last_q;
    assign bus.err_timeout = err_q;
    assign bus.blk_cnt     = blk_cnt_q;

endmodule

// File: tb/tb_aes_dec_cbc_ctrl.sv
// Bench for aes_dec_cbc_ctrl: fake AES core with programmable latency/stale done,
// CBC reference model with an expected-output queue, and directed scenarios.
module tb_aes_dec_cbc_ctrl;
    localparam int unsigned TO = 32;
    localparam logic [127:0] CT_A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_A = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_B = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] JUNK = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    localparam logic [127:0] ONES = {128{1'b1}};

    typedef struct packed {
        logic [127:0] ptxt;
        logic         last;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    int           n_cmp = 0;
    int           n_bad = 0;
    exp_t         exp_q[$];
    logic [127:0] model_iv;
    logic [127:0] model_chain;
    logic [15:0]  exp_cnt;
    logic         exp_err;

    // fake core controls
    int           lat   = 5;
    bit           stale = 1'b0;
    bit           alive = 1'b1;
    int           rc    = 0;

    aes_dec_cbc_ctrl_if bus ();

    aes_dec_cbc_ctrl #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // AES-128 decrypt for key 000102..0f is known for CT_A; other blocks use a stand-in bijection.
    function automatic logic [127:0] core_dec(input logic [127:0] ct);
        if (ct == CT_A) return PT_A;
        return {ct[63:0], ct[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    // rc = cycles since the core saw core_rst low
    always @(posedge clk) begin
        if (bus.core_rst) rc <= 0;
        else if (rc < 1000) rc <= rc + 1;
    end
    assign bus.core_done = alive && ((stale && (rc < 2)) || (rc >= lat));
    assign bus.core_ptxt = (alive && (rc >= lat)) ? core_dec(bus.core_ctxt) : JUNK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 128'(act), 128'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_cnt     = '0;
        exp_err     = 1'b0;
        model_iv    = '0;
        model_chain = '0;
    endtask

    task automatic send(input logic [127:0] ct, input logic last, input bit completes,
                        input bit ld, input logic [127:0] ivv);
        int   k;
        exp_t e;
        k = 0;
        bus.s_valid = 1'b1;
        bus.s_ctxt  = ct;
        bus.s_last  = last;
        if (ld) begin
            bus.iv_load = 1'b1;
            bus.iv      = ivv;
        end
        while (!bus.s_ready && k < 200) begin
            tick();
            k++;
        end
        chk1("accept_ready", bus.s_ready, 1'b1);
        tick();
        bus.s_valid = 1'b0;
        bus.iv_load = 1'b0;
        if (ld) begin
            model_iv    = ivv;
            model_chain = ivv;
        end
        if (completes) begin
            e.ptxt = core_dec(ct) ^ model_chain;
            e.last = last;
            exp_q.push_back(e);
            model_chain = last ? model_iv : ct;
        end
    endtask

    task automatic load_iv(input logic [127:0] v);
        bus.iv_load = 1'b1;
        bus.iv      = v;
        tick();
        bus.iv_load = 1'b0;
        model_iv    = v;
        model_chain = v;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            tick();
            k++;
        end
        chk({"drain_", name}, 128'(exp_q.size()), 128'd0);
    endtask

    // Per-cycle check of all outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk1("rst_core_rst", bus.core_rst, 1'b1);
                chk1("rst_m_valid", bus.m_valid, 1'b0);
                chk("rst_m_ptxt", bus.m_ptxt, '0);
                chk1("rst_m_last", bus.m_last, 1'b0);
                chk("rst_core_ctxt", bus.core_ctxt, '0);
                chk1("rst_err", bus.err_timeout, 1'b0);
                chk("rst_blk_cnt", 128'(bus.blk_cnt), 128'd0);
            end else begin
                chk("blk_cnt", 128'(bus.blk_cnt), 128'(exp_cnt));
                chk1("err_timeout", bus.err_timeout, exp_err);
                if (bus.m_valid) begin
                    chk1("s_ready_in_out", bus.s_ready, 1'b0);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL spurious_m_valid: got m_valid=1, expected 0 (no block outstanding)");
                    end else begin
                        chk("m_ptxt", bus.m_ptxt, exp_q[0].ptxt);
                        chk1("m_last", bus.m_last, exp_q[0].last);
                        if (bus.m_ready) begin
                            void'(exp_q.pop_front());
                            exp_cnt = exp_cnt + 16'd1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        bus.iv_load = 1'b0;
        bus.iv      = '0;
        bus.s_valid = 1'b0;
        bus.s_ctxt  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;
        reset       = 1'b1;
        model_clear();

        // reset state
        repeat (3) tick();
        chk1("reset_s_ready", bus.s_ready, 1'b1);
        chk1("reset_m_valid", bus.m_valid, 1'b0);
        chk1("reset_core_rst", bus.core_rst, 1'b1);
        reset = 1'b0;
        tick();
        chk1("core_rst_after_release", bus.core_rst, 1'b0);

        // single-block message, IV = 0
        lat = 5;
        send(CT_A, 1'b1, 1'b1, 1'b0, '0);
        drain("single");
        chk("single_ptxt", bus.m_ptxt, PT_A);
        chk1("single_last", bus.m_last, 1'b1);
        chk("single_cnt", 128'(bus.blk_cnt), 128'd1);

        // IV = 1 loaded on the same edge the block is accepted
        send(CT_A, 1'b1, 1'b1, 1'b1, 128'h1);
        drain("iv1");
        chk("iv1_ptxt", bus.m_ptxt, 128'h00112233445566778899aabbccddeefe);
        chk("iv1_cnt", 128'(bus.blk_cnt), 128'd2);

        // two-block message then a fresh message: chain reloads from IV after last
        load_iv('0);
        send(CT_A, 1'b0, 1'b1, 1'b0, '0);
        send(CT_A, 1'b1, 1'b1, 1'b0, '0);
        drain("chain2");
        chk("chain2_ptxt", bus.m_ptxt, 128'h69d5c2eb2e2e624750541d3bbc692ba5);
        chk1("chain2_last", bus.m_last, 1'b1);
        chk("chain2_cnt", 128'(bus.blk_cnt), 128'd4);
        send(CT_A, 1'b1, 1'b1, 1'b0, '0);
        drain("chain3");
        chk("chain3_ptxt", bus.m_ptxt, PT_A);

        // iv_load while busy must be ignored
        lat = 8;
        send(CT_A, 1'b1, 1'b1, 1'b0, '0);
        tick();
        bus.iv_load = 1'b1;
        bus.iv      = ONES;
        tick();
        bus.iv_load = 1'b0;
        drain("ivbusy1");
        send(CT_A, 1'b1, 1'b1, 1'b0, '0);
        drain("ivbusy2");
        chk("ivbusy_ptxt", bus.m_ptxt, PT_A);
        chk("ivbusy_cnt", 128'(bus.blk_cnt), 128'd7);

        // core_done held high: only sampled at counter 2, m_valid 4 edges after accept
        stale = 1'b1;
        lat   = 2;
        send(CT_A, 1'b1, 1'b1, 1'b0, '0);
        k = 0;
        while (!bus.m_valid && k < 20) begin
            tick();
            k++;
        end
        chk("const_done_latency", 128'(k), 128'd4);
        chk("const_done_ptxt", bus.m_ptxt, PT_A);
        drain("const_done");
        stale = 1'b0;

        // sink stalls for 5 cycles
        lat = 3;
        bus.m_ready = 1'b0;
        send(CT_A, 1'b1, 1'b1, 1'b0, '0);
        k = 0;
        while (!bus.m_valid && k < 50) begin
            tick();
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            chk1("hold_m_valid", bus.m_valid, 1'b1);
            chk("hold_ptxt", bus.m_ptxt, PT_A);
            chk1("hold_s_ready", bus.s_ready, 1'b0);
            chk("hold_cnt", 128'(bus.blk_cnt), 128'd8);
            tick();
        end
        bus.m_ready = 1'b1;
        tick();
        chk1("release_m_valid", bus.m_valid, 1'b0);
        chk1("release_s_ready", bus.s_ready, 1'b1);
        chk("release_cnt", 128'(bus.blk_cnt), 128'd9);

        // stale done with junk data, then a slower real result
        stale = 1'b1;
        lat   = 6;
        send(CT_B, 1'b0, 1'b1, 1'b0, '0);
        drain("stale");
        stale = 1'b0;

        // dead core: timeout after 32 WAIT cycles, block discarded, chain kept at CT_B
        alive = 1'b0;
        send(CT_A, 1'b0, 1'b0, 1'b0, '0);
        repeat (32) tick();
        chk1("pre_timeout_err", bus.err_timeout, 1'b0);
        chk1("pre_timeout_s_ready", bus.s_ready, 1'b0);
        tick();
        exp_err = 1'b1;
        chk1("timeout_err", bus.err_timeout, 1'b1);
        chk1("timeout_s_ready", bus.s_ready, 1'b1);
        chk("timeout_cnt", 128'(bus.blk_cnt), 128'd10);
        alive = 1'b1;
        lat   = 3;
        send(CT_A, 1'b1, 1'b1, 1'b0, '0);
        drain("post_timeout");
        chk("post_timeout_ptxt", bus.m_ptxt, PT_A ^ CT_B);
        chk1("post_timeout_err_sticky", bus.err_timeout, 1'b1);

        // reset mid-WAIT abandons the block
        lat = 20;
        send(CT_A, 1'b1, 1'b1, 1'b0, '0);
        repeat (5) tick();
        reset = 1'b1;
        model_clear();
        #1;
        chk1("midrst_m_valid", bus.m_valid, 1'b0);
        chk1("midrst_core_rst", bus.core_rst, 1'b1);
        chk("midrst_m_ptxt", bus.m_ptxt, '0);
        chk("midrst_core_ctxt", bus.core_ctxt, '0);
        chk1("midrst_err", bus.err_timeout, 1'b0);
        chk("midrst_cnt", 128'(bus.blk_cnt), 128'd0);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk1("midrst_core_rst_release", bus.core_rst, 1'b0);
        repeat (30) tick();
        lat = 4;
        send(CT_A, 1'b1, 1'b1, 1'b0, '0);
        drain("after_reset");
        chk("after_reset_ptxt", bus.m_ptxt, PT_A);
        chk("after_reset_cnt", 128'(bus.blk_cnt), 128'd1);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
